// File: rtl/pc_fetch_unit.sv
// Instruction fetch stage: program counter, IF/ID pipeline register and a
// run/halt sequencer that stops fetching when the halt encoding is seen.
module pc_fetch_unit #(
  parameter logic [4:0]  RESET_PC  = 5'd0,
  parameter logic [31:0] HALT_WORD = 32'hFFFFFFFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic        branch_taken,
  input  logic [4:0]  branch_target,
  input  logic        jump,
  input  logic [4:0]  jump_target,
  input  logic [31:0] instr_in,
  output logic [4:0]  pc_out,
  output logic [31:0] ifid_instr,
  output logic [4:0]  ifid_pc,
  output logic        ifid_valid,
  output logic        halted,
  output logic [7:0]  fetch_count
);

  // state  | meaning
  // IDLE   | one settling cycle after reset, PC at RESET_PC, no fetch
  // RUN    | normal fetch, redirects/stall/flush honoured
  // HALTED | halt word seen; PC frozen, bubbles only, left only by reset
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALTED} state_t;

  state_t      state_q, state_d;
  logic [4:0]  pc_q, pc_d;
  logic        redirect, is_halt, halt_hit;
  logic        load_instr, load_bubble;

  assign redirect = jump | branch_taken;
  assign is_halt  = (instr_in == HALT_WORD);
  // A halt word only counts when nothing else would squash or hold it
  assign halt_hit = (state_q == S_RUN) && is_halt && !redirect && !flush && !stall;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   state_d = S_RUN;
      S_RUN:    if (halt_hit) state_d = S_HALTED;
      S_HALTED: state_d = S_HALTED;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    pc_d        = pc_q;
    load_instr  = 1'b0;
    load_bubble = 1'b0;
    case (state_q)
      S_RUN: begin
        if (jump)                    pc_d = jump_target;
        else if (branch_taken)       pc_d = branch_target;
        else if (stall || halt_hit)  pc_d = pc_q;
        else                         pc_d = pc_q + 5'd1;
        load_bubble = redirect | flush | halt_hit;
        load_instr  = !redirect && !flush && !stall && !is_halt;
      end
      S_HALTED: load_bubble = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q        <= RESET_PC;
      ifid_instr  <= 32'd0;
      ifid_pc     <= 5'd0;
      ifid_valid  <= 1'b0;
      fetch_count <= 8'd0;
    end else begin
      pc_q <= pc_d;
      if (load_bubble) begin
        ifid_instr <= 32'd0;
        ifid_pc    <= 5'd0;
        ifid_valid <= 1'b0;
      end else if (load_instr) begin
        ifid_instr <= instr_in;
        ifid_pc    <= pc_q;
        ifid_valid <= 1'b1;
      end
      if (load_instr && (fetch_count != 8'hFF))
        fetch_count <= fetch_count + 8'd1;
    end
  end

  assign pc_out = pc_q;
  assign halted = (state_q == S_HALTED);

endmodule
